// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader FSM encoding and the frame marker bytes.
// Imported by mem_loader; nothing here generates logic on its own.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    SYNC   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DAT_HI = 3'd3,
    DAT_LO = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CSUM_GOOD = 8'h00;

endpackage

// File: rtl/mem_loader.sv
// Boot loader: parses A5/count/data/checksum frames into 16-bit memory writes, holding the CPU in reset.
// Latency: a write strobe appears the cycle after the data-lo byte; done/err the cycle after the deciding byte.
// Backpressure: none while loading (one byte per cycle); in_ready drops only once the load is done.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int LOAD_BASE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  // Index is one bit wider than the address so a full-memory count fits.
  localparam int IDX_W = ADDR_WIDTH + 1;
  // Largest word count that fits between LOAD_BASE and the top of memory.
  localparam logic [32:0] MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(LOAD_BASE);

  loader_state_t    state;
  loader_state_t    state_nxt;
  logic [7:0]       xacc;
  logic [7:0]       xacc_nxt;
  logic [7:0]       cnt_hi;
  logic [15:0]      count;
  logic [15:0]      count_full;
  logic [7:0]       dat_hi;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] idx_inc;
  logic             accept;

  // Next-state decode; every transition is gated on an accepted byte.
  always_comb begin
    accept     = in_valid && in_ready;
    xacc_nxt   = xacc ^ in_data;
    count_full = {cnt_hi, in_data};
    idx_inc    = index + IDX_W'(1);
    state_nxt  = state;
    if (accept) begin
      case (state)
        SYNC:   if (in_data == SYNC_BYTE) state_nxt = CNT_HI;
        CNT_HI: state_nxt = CNT_LO;
        CNT_LO: begin
          if (count_full == 16'd0)                  state_nxt = CSUM;
          else if (33'(count_full) > MAX_WORDS)     state_nxt = ERR;
          else                                      state_nxt = DAT_HI;
        end
        DAT_HI: state_nxt = DAT_LO;
        DAT_LO: begin
          if (33'(idx_inc) == 33'(count)) state_nxt = CSUM;
          else                            state_nxt = DAT_HI;
        end
        CSUM:   state_nxt = (xacc_nxt == CSUM_GOOD) ? DONE : ERR;
        DONE:   state_nxt = DONE;
        ERR:    if (in_data == SYNC_BYTE) state_nxt = CNT_HI;
        default: state_nxt = SYNC;
      endcase
    end
  end

  // FSM state, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYNC;
      xacc     <= 8'd0;
      cnt_hi   <= 8'd0;
      count    <= 16'd0;
      dat_hi   <= 8'd0;
      index    <= '0;
      in_ready <= 1'b1;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != DONE);
      cpu_hold <= (state_nxt != DONE);
      done     <= (state_nxt == DONE);
      err      <= (state_nxt == ERR);
      wr_en    <= 1'b0;
      if (accept) begin
        case (state)
          SYNC, ERR: begin
            // A fresh sync restarts the checksum and the write pointer.
            if (in_data == SYNC_BYTE) begin
              xacc  <= 8'd0;
              index <= '0;
            end
          end
          CNT_HI: begin
            cnt_hi <= in_data;
            xacc   <= xacc_nxt;
          end
          CNT_LO: begin
            count <= count_full;
            xacc  <= xacc_nxt;
          end
          DAT_HI: begin
            dat_hi <= in_data;
            xacc   <= xacc_nxt;
          end
          DAT_LO: begin
            // Written before the checksum is known; cpu_hold covers a bad image.
            wr_en   <= 1'b1;
            wr_addr <= index[ADDR_WIDTH-1:0] + ADDR_WIDTH'(LOAD_BASE);
            wr_data <= DATA_WIDTH'({dat_hi, in_data});
            index   <= idx_inc;
            xacc    <= xacc_nxt;
          end
          CSUM: xacc <= xacc_nxt;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: frame table, hand-written corner sequences, random frames.
// Expected writes/status come from the frame contents (pairs of bytes, XOR of the frame).
// Bounded run; ends with a single summary line.
module tb_mem_loader;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int LB = 0;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] wr_q_t[$];

  typedef struct {
    logic [7:0]  b [0:7];
    int          nb;
    int          nwr;
    logic [12:0] last_addr;
    logic [15:0] last_data;
    logic        exp_done;
    logic        exp_err;
    logic        exp_hold;
    logic        exp_rdy;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int n_chk = 0;
  int n_fail = 0;

  // Written only by the monitor process.
  wr_q_t wr_q;
  int    wr_total = 0;
  int    b2b_viol = 0;
  int    hold_viol = 0;
  logic  prev_wr = 1'b0;

  mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_BASE(LB)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Capture every write strobe away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      wr_q.delete();
      prev_wr <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_q.push_back(32'({wr_addr, wr_data}));
        wr_total <= wr_total + 1;
        if (prev_wr)   b2b_viol  <= b2b_viol + 1;
        if (!cpu_hold) hold_viol <= hold_viol + 1;
      end
      prev_wr <= wr_en;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t q, input bit gaps);
    foreach (q[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 8'($urandom);
        end
      end
      send_byte(q[i]);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic check_writes(input string name, input wr_q_t exp_q);
    int mism = 0;
    chk({name, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
    if (wr_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) mism++;
    end
    chk({name, "_wrdata_mism"}, 32'(mism), 32'd0);
  endtask

  task automatic check_status(input string name, input logic d, input logic e, input logic h, input logic r);
    chk({name, "_done"},     32'(done),     32'(d));
    chk({name, "_err"},      32'(err),      32'(e));
    chk({name, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
    chk({name, "_in_ready"}, 32'(in_ready), 32'(r));
  endtask

  initial begin
    vec_t    tbl [0:3];
    byte_q_t fq;
    wr_q_t   eq;
    logic [7:0]  x;
    logic [15:0] w;
    int n;
    int tot;
    bit bad;

    // Frame table: inputs and hand-computed outcomes.
    tbl[0].b = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    tbl[0].nb = 8; tbl[0].nwr = 2; tbl[0].last_addr = 13'h1; tbl[0].last_data = 16'hABCD;
    tbl[0].exp_done = 1; tbl[0].exp_err = 0; tbl[0].exp_hold = 0; tbl[0].exp_rdy = 0;
    tbl[1].b = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    tbl[1].nb = 8; tbl[1].nwr = 2; tbl[1].last_addr = 13'h1; tbl[1].last_data = 16'hABCD;
    tbl[1].exp_done = 0; tbl[1].exp_err = 1; tbl[1].exp_hold = 1; tbl[1].exp_rdy = 1;
    tbl[2].b = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].nb = 7; tbl[2].nwr = 0; tbl[2].last_addr = 13'h0; tbl[2].last_data = 16'h0;
    tbl[2].exp_done = 1; tbl[2].exp_err = 0; tbl[2].exp_hold = 0; tbl[2].exp_rdy = 0;
    tbl[3].b = '{8'hA5, 8'h20, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3].nb = 3; tbl[3].nwr = 0; tbl[3].last_addr = 13'h0; tbl[3].last_data = 16'h0;
    tbl[3].exp_done = 0; tbl[3].exp_err = 1; tbl[3].exp_hold = 1; tbl[3].exp_rdy = 1;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    check_status("reset", 0, 0, 1, 1);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int j = 0; j < tbl[i].nb; j++) send_byte(tbl[i].b[j]);
      idle();
      @(negedge clk);
      chk($sformatf("tbl%0d_nwr", i), 32'(wr_q.size()), 32'(tbl[i].nwr));
      if (tbl[i].nwr > 0 && wr_q.size() > 0) begin
        chk($sformatf("tbl%0d_first", i), wr_q[0], 32'({13'h0, 16'h1234}));
        chk($sformatf("tbl%0d_last", i), wr_q[wr_q.size()-1],
            32'({tbl[i].last_addr, tbl[i].last_data}));
      end
      check_status($sformatf("tbl%0d", i), tbl[i].exp_done, tbl[i].exp_err,
                   tbl[i].exp_hold, tbl[i].exp_rdy);
    end

    // Write latency and err timing on the oversize count.
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_wr_en_k1", 32'(wr_en), 32'd1);
    chk("lat_wr_word", 32'({wr_addr, wr_data}), 32'({13'h0, 16'h1234}));
    @(negedge clk);
    chk("lat_wr_en_k2", 32'(wr_en), 32'd0);
    do_reset();
    send_byte(8'hA5); send_byte(8'h20);
    @(negedge clk);
    chk("err_before_cntlo", 32'(err), 32'd0);
    in_data = 8'h01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("err_after_cntlo", 32'(err), 32'd1);

    // Bad checksum then host retry without reset.
    do_reset();
    send_frame('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43}, 1'b0);
    chk("retry_err_set", 32'(err), 32'd1);
    send_byte(8'hA5);
    idle();
    chk("retry_err_clr", 32'(err), 32'd0);
    send_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42}, 1'b0);
    check_writes("retry", '{32'({13'h0, 16'h1234}), 32'({13'h1, 16'hABCD}),
                            32'({13'h0, 16'h1234}), 32'({13'h1, 16'hABCD})});
    check_status("retry", 1, 0, 0, 0);

    // Reset between data hi and data lo of word 1.
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    @(negedge clk);
    chk("midrst_pre_nwr", 32'(wr_q.size()), 32'd1);
    tot = wr_total;
    rst = 1'b1;
    in_data = 8'hCD;
    @(negedge clk);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    check_status("midrst", 0, 0, 1, 1);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_no_write", 32'(wr_total), 32'(tot));
    send_frame('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42}, 1'b1);
    check_writes("midrst_resend", '{32'({13'h0, 16'h1234}), 32'({13'h1, 16'hABCD})});
    check_status("midrst_resend", 1, 0, 0, 0);

    // Randomized frames against a frame-level model.
    for (int f = 0; f < 25; f++) begin
      do_reset();
      fq.delete();
      eq.delete();
      repeat ($urandom_range(0, 3)) begin
        x = 8'($urandom);
        if (x == 8'hA5) x = 8'h5A;
        fq.push_back(x);
      end
      n = $urandom_range(0, 6);
      fq.push_back(8'hA5);
      fq.push_back(8'(n >> 8));
      fq.push_back(8'(n));
      x = 8'(n >> 8) ^ 8'(n);
      for (int k = 0; k < n; k++) begin
        w = 16'($urandom);
        fq.push_back(w[15:8]);
        fq.push_back(w[7:0]);
        x = x ^ w[15:8] ^ w[7:0];
        eq.push_back(32'({13'((LB + k) % (1 << AW)), w}));
      end
      bad = ($urandom_range(0, 3) == 0);
      if (bad) x = x ^ 8'($urandom_range(1, 255));
      fq.push_back(x);
      send_frame(fq, 1'b1);
      check_writes($sformatf("rnd%0d", f), eq);
      check_status($sformatf("rnd%0d", f), !bad, bad, bad, bad);
    end

    // Full-size load: data equals index across the whole memory.
    do_reset();
    fq.delete();
    eq.delete();
    fq.push_back(8'h20);
    fq.push_back(8'h00);
    x = 8'h20;
    fq.push_front(8'hA5);
    for (int k = 0; k < (1 << AW); k++) begin
      w = 16'(k);
      fq.push_back(w[15:8]);
      fq.push_back(w[7:0]);
      x = x ^ w[15:8] ^ w[7:0];
      eq.push_back(32'({13'(k), w}));
    end
    fq.push_back(x);
    send_frame(fq, 1'b0);
    check_writes("full", eq);
    if (wr_q.size() > 0) chk("full_last", wr_q[wr_q.size()-1], 32'({13'h1FFF, 16'h1FFF}));
    check_status("full", 1, 0, 0, 0);

    chk("wr_spacing_viol", 32'(b2b_viol), 32'd0);
    chk("wr_without_hold", 32'(hold_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

endmodule
